// File: rtl/ahb_slave_port_arbiter_pkg.sv
// AHB_package: shared AHB definitions for the generated interconnect.
//   htrans_t        : HTRANS encoding (IDLE, BUSY, NONSEQ, SEQ)
//   MAX_MASTER_NUM  : upper bound on masters competing for one slave port
package AHB_package;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_t;

  localparam int MAX_MASTER_NUM = 16;

endpackage

// File: rtl/ahb_slave_port_arbiter_rr_picker.sv
// ahb_rr_picker: purely combinational round-robin selector, reusable by any
// port that arbitrates among requesters.
// Ports:
//   req            in  N : request vector
//   last_onehot    in  N : one-hot index of the previous winner
//   winner_onehot  out N : one-hot winner (zero when no request)
//   any_req        out 1 : OR of req
module ahb_rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] last_onehot,
  output logic [N-1:0] winner_onehot,
  output logic         any_req
);

  int  last_idx;
  int  idx;
  logic found;

  // Scan from the slot after the previous winner, wrapping; the previous
  // winner itself is visited last so it has the lowest priority.
  always_comb begin
    winner_onehot = '0;
    found         = 1'b0;
    last_idx      = 0;
    idx           = 0;
    for (int i = 0; i < N; i++) begin
      if (last_onehot[i]) last_idx = i;
    end
    for (int k = 1; k <= N; k++) begin
      idx = last_idx + k;
      if (idx >= N) idx = idx - N;
      for (int j = 0; j < N; j++) begin
        if (!found && (j == idx) && req[j]) begin
          winner_onehot[j] = 1'b1;
          found            = 1'b1;
        end
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/ahb_slave_port_arbiter.sv
// ahb_slave_port_arbiter: per-slave address-phase arbitration and data-phase
// owner tracking for the AHB interconnect (master-to-slave direction).
// Ports:
//   HCLK       in  1       : clock
//   HRESET     in  1       : synchronous active-high reset
//   hreq       in  M       : per-master hit on this slave with NONSEQ/SEQ
//   htrans     in  2*M     : per-master HTRANS, master i at [2i+1:2i]
//   hmastlock  in  M       : per-master HMASTLOCK
//   hready_in  in  1       : HREADYOUT of the slave
//   addr_sel   out M       : one-hot address-phase owner (registered)
//   data_sel   out M       : one-hot or zero data-phase owner (registered)
//   hready_m   out M       : per-master HREADY contribution (combinational)
//   hsel_out   out 1       : HSEL to the slave (combinational)
module ahb_slave_port_arbiter
  import AHB_package::*;
#(
  parameter int MASTER_NUM = 4
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic [MASTER_NUM-1:0]   hreq,
  input  logic [2*MASTER_NUM-1:0] htrans,
  input  logic [MASTER_NUM-1:0]   hmastlock,
  input  logic                    hready_in,
  output logic [MASTER_NUM-1:0]   addr_sel,
  output logic [MASTER_NUM-1:0]   data_sel,
  output logic [MASTER_NUM-1:0]   hready_m,
  output logic                    hsel_out
);

  logic [MASTER_NUM-1:0] winner;
  logic                  any_req;
  logic [MASTER_NUM-1:0] hold_vec;
  logic                  hold;

  ahb_rr_picker #(.N(MASTER_NUM)) u_picker (
    .req           (hreq),
    .last_onehot   (addr_sel),
    .winner_onehot (winner),
    .any_req       (any_req)
  );

  // The owner keeps the port while it is mid-burst (SEQ/BUSY) or locked,
  // as long as it is still requesting this slave.
  always_comb begin
    hold_vec = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      hold_vec[i] = addr_sel[i] & hreq[i] &
                    ((htrans[2*i +: 2] == SEQ) || (htrans[2*i +: 2] == BUSY) ||
                     hmastlock[i]);
    end
    hold = |hold_vec;
  end

  // Both registers advance only on accepted cycles; with no requests the
  // last owner stays parked so addr_sel is never zero.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_sel <= MASTER_NUM'(1);
      data_sel <= '0;
    end else if (hready_in) begin
      if (!hold && any_req) addr_sel <= winner;
      data_sel <= addr_sel & hreq;
    end
  end

  // Stall a master whose data phase is waiting, or who requests without
  // holding the address phase on an accepted cycle.
  assign hready_m = (~data_sel | {MASTER_NUM{hready_in}}) &
                    (~hreq | (addr_sel & {MASTER_NUM{hready_in}}));

  assign hsel_out = |(hreq & addr_sel);

endmodule

// File: tb/tb_ahb_slave_port_arbiter.sv
// tb_ahb_slave_port_arbiter: directed, table-driven check of the slave port
// arbiter with four masters. Each record holds the inputs for one cycle and
// the outputs expected while those inputs are applied, before the next edge.
module tb_ahb_slave_port_arbiter;

  logic       HCLK;
  logic       HRESET;
  logic [3:0] hreq;
  logic [7:0] htrans;
  logic [3:0] hmastlock;
  logic       hready_in;
  logic [3:0] addr_sel;
  logic [3:0] data_sel;
  logic [3:0] hready_m;
  logic       hsel_out;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic [3:0] hreq;
    logic [7:0] htrans;
    logic [3:0] lock;
    logic       rdy;
    logic [3:0] exp_addr;
    logic [3:0] exp_data;
    logic [3:0] exp_hrm;
    logic       exp_hsel;
  } vec_t;

  vec_t rr_tab[8];

  ahb_slave_port_arbiter #(.MASTER_NUM(4)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .hreq      (hreq),
    .htrans    (htrans),
    .hmastlock (hmastlock),
    .hready_in (hready_in),
    .addr_sel  (addr_sel),
    .data_sel  (data_sel),
    .hready_m  (hready_m),
    .hsel_out  (hsel_out)
  );

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  function automatic vec_t mk(input logic rst, input logic [3:0] rq,
                              input logic [7:0] tr, input logic [3:0] lk,
                              input logic rdy, input logic [3:0] ea,
                              input logic [3:0] ed, input logic [3:0] eh,
                              input logic es);
    vec_t v;
    v.rst = rst; v.hreq = rq; v.htrans = tr; v.lock = lk; v.rdy = rdy;
    v.exp_addr = ea; v.exp_data = ed; v.exp_hrm = eh; v.exp_hsel = es;
    return v;
  endfunction

  // Drive one cycle's worth of inputs.
  task automatic applyStimulus(input vec_t v);
    HRESET    = v.rst;
    hreq      = v.hreq;
    htrans    = v.htrans;
    hmastlock = v.lock;
    hready_in = v.rdy;
  endtask

  // Compare every output against the record's expectations.
  task automatic checkOutput(input string name, input vec_t v);
    checks++;
    if (addr_sel !== v.exp_addr) begin
      failures++;
      $display("[TB] FAIL %s addr_sel actual=%b expected=%b", name, addr_sel, v.exp_addr);
    end
    checks++;
    if (data_sel !== v.exp_data) begin
      failures++;
      $display("[TB] FAIL %s data_sel actual=%b expected=%b", name, data_sel, v.exp_data);
    end
    checks++;
    if (hready_m !== v.exp_hrm) begin
      failures++;
      $display("[TB] FAIL %s hready_m actual=%b expected=%b", name, hready_m, v.exp_hrm);
    end
    checks++;
    if (hsel_out !== v.exp_hsel) begin
      failures++;
      $display("[TB] FAIL %s hsel_out actual=%b expected=%b", name, hsel_out, v.exp_hsel);
    end
  endtask

  // Apply, sample mid-cycle, then advance past the next rising edge.
  task automatic runStep(input string name, input vec_t v);
    applyStimulus(v);
    #2;
    checkOutput(name, v);
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    // rst, hreq, htrans, lock, rdy, exp addr_sel, data_sel, hready_m, hsel
    rr_tab[0] = mk(0, 4'b0000, 8'h00, 4'b0000, 1, 4'b0001, 4'b0000, 4'b1111, 0);
    rr_tab[1] = mk(0, 4'b0000, 8'h00, 4'b0000, 1, 4'b0001, 4'b0000, 4'b1111, 0);
    rr_tab[2] = mk(0, 4'b1111, 8'hAA, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0001, 1);
    rr_tab[3] = mk(0, 4'b1111, 8'hAA, 4'b0000, 1, 4'b0010, 4'b0001, 4'b0010, 1);
    rr_tab[4] = mk(0, 4'b1111, 8'hAA, 4'b0000, 1, 4'b0100, 4'b0010, 4'b0100, 1);
    rr_tab[5] = mk(0, 4'b1111, 8'hAA, 4'b0000, 1, 4'b1000, 4'b0100, 4'b1000, 1);
    rr_tab[6] = mk(0, 4'b1111, 8'hAA, 4'b0000, 1, 4'b0001, 4'b1000, 4'b0001, 1);
    rr_tab[7] = mk(0, 4'b0000, 8'h00, 4'b0000, 1, 4'b0010, 4'b0001, 4'b1111, 0);

    HRESET = 1'b1; hreq = '0; htrans = '0; hmastlock = '0; hready_in = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;

    // Parking after reset, then round-robin 1,2,3,0,1 and park on master 1.
    for (int i = 0; i < 8; i++) begin
      runStep($sformatf("rr_vec%0d", i), rr_tab[i]);
    end

    // Burst hold: master 2 gets the port, runs NONSEQ + 3 SEQ while master 0 waits.
    runStep("burst_grant",  mk(0, 4'b0100, 8'h20, 4'b0000, 1, 4'b0010, 4'b0000, 4'b1011, 0));
    runStep("burst_nonseq", mk(0, 4'b0100, 8'h20, 4'b0000, 1, 4'b0100, 4'b0000, 4'b1111, 1));
    runStep("burst_seq1",   mk(0, 4'b0101, 8'h32, 4'b0000, 1, 4'b0100, 4'b0100, 4'b1110, 1));
    runStep("burst_seq2",   mk(0, 4'b0101, 8'h32, 4'b0000, 1, 4'b0100, 4'b0100, 4'b1110, 1));
    runStep("burst_seq3",   mk(0, 4'b0101, 8'h32, 4'b0000, 1, 4'b0100, 4'b0100, 4'b1110, 1));
    runStep("burst_end",    mk(0, 4'b0001, 8'h02, 4'b0000, 1, 4'b0100, 4'b0100, 4'b1110, 0));
    runStep("burst_m0",     mk(0, 4'b0001, 8'h02, 4'b0000, 1, 4'b0001, 4'b0000, 4'b1111, 1));

    // Wait states during master 1's data phase; master 3 requests meanwhile.
    runStep("wait_grant",   mk(0, 4'b0010, 8'h08, 4'b0000, 1, 4'b0001, 4'b0001, 4'b1101, 0));
    runStep("wait_addr",    mk(0, 4'b0010, 8'h08, 4'b0000, 1, 4'b0010, 4'b0000, 4'b1111, 1));
    for (int i = 0; i < 3; i++) begin
      runStep($sformatf("wait_ws%0d", i),
              mk(0, 4'b1000, 8'h80, 4'b0000, 0, 4'b0010, 4'b0010, 4'b0101, 0));
    end
    runStep("wait_release", mk(0, 4'b1000, 8'h80, 4'b0000, 1, 4'b0010, 4'b0010, 4'b0111, 0));

    // Locked NONSEQ transfers by master 3 with master 1 requesting.
    for (int i = 0; i < 3; i++) begin
      runStep($sformatf("lock_xfer%0d", i),
              mk(0, 4'b1010, 8'h88, 4'b1000, 1, 4'b1000, (i == 0) ? 4'b0000 : 4'b1000, 4'b1101, 1));
    end
    runStep("lock_drop",    mk(0, 4'b1010, 8'h88, 4'b0000, 1, 4'b1000, 4'b1000, 4'b1101, 1));
    runStep("lock_m1",      mk(0, 4'b0010, 8'h08, 4'b0000, 1, 4'b0010, 4'b1000, 4'b1111, 1));

    // Reset asserted during master 2's SEQ beat.
    runStep("rst_grant",    mk(0, 4'b0100, 8'h20, 4'b0000, 1, 4'b0010, 4'b0010, 4'b1011, 0));
    runStep("rst_nonseq",   mk(0, 4'b0100, 8'h20, 4'b0000, 1, 4'b0100, 4'b0000, 4'b1111, 1));
    runStep("rst_seq",      mk(1, 4'b0100, 8'h30, 4'b0000, 1, 4'b0100, 4'b0100, 4'b1111, 1));
    runStep("rst_after",    mk(0, 4'b0100, 8'h30, 4'b0000, 1, 4'b0001, 4'b0000, 4'b1011, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_slave_port_arbiter.md
# ahb_slave_port_arbiter

Per-slave arbitration and routing control for the generated AHB interconnect. It handles the master-to-slave direction: it picks which master owns the slave's address phase, and tracks which master owns the data phase. Its select vectors drive the slave-side request mux and the master-side response mux. One instance sits in front of each slave port.

## Interface
- `MASTER_NUM`, default 4: number of masters competing for this slave; 1..16.
- `HCLK`, in, 1: sole clock.
- `HRESET`, in, 1: reset, synchronous and active-high.
- `hreq`, in, `MASTER_NUM`: per master, decoder hit on this slave AND `HTRANS` is NONSEQ or SEQ.
- `htrans`, in, `MASTER_NUM`×2: per-master `HTRANS`.
- `hmastlock`, in, `MASTER_NUM`: per-master `HMASTLOCK`.
- `hready_in`, in, 1: `HREADYOUT` of this slave.
- `addr_sel`, out, `MASTER_NUM`: one-hot address-phase owner; feeds the slave-side request mux select.
- `data_sel`, out, `MASTER_NUM`: one-hot or zero data-phase owner; feeds the response mux select.
- `hready_m`, out, `MASTER_NUM`: this port's per-master HREADY contribution; ANDed with other ports outside this block.
- `hsel_out`, out, 1: `HSEL` to the slave, equal to `|(hreq & addr_sel)`.

## Operation
- The owner register holds `addr_sel`. The update happens only on cycles where `hready_in` = 1.
- **Hold condition.** Keep the current owner when its `hreq` = 1 and either of these is true:
  - its `htrans` is SEQ or BUSY, meaning a burst is in progress;
  - its `hmastlock` = 1.
- **Arbitration.** Otherwise, if any `hreq` bit is set, load the round-robin winner.
  - The search starts at index (owner + 1) mod `MASTER_NUM`, increasing and wrapping.
  - The first requester found wins. The current owner has the lowest priority.
- **Parking.** With no requests, `addr_sel` is unchanged; the last owner stays parked.
- **Data-phase owner.** When `hready_in` = 1, `data_sel` <= `addr_sel & hreq`. Zero means an IDLE or non-owned cycle. When `hready_in` = 0, `data_sel` holds.
- **Per-master HREADY.** `hready_m[i]` = (`~data_sel[i]` | `hready_in`) & (`~hreq[i]` | (`addr_sel[i]` & `hready_in`)).
  - A requesting master that is not granted is stalled.
  - A master not involved with this slave sees 1.
- **Grant latency.** A new request from a non-owner is stalled for at least one cycle before its address is accepted.
- **Invariants.**
  - `addr_sel` is always exactly one-hot.
  - `data_sel` is one-hot or zero.
  - `MASTER_NUM` = 1 collapses to a constant grant.

## Timing
- **Reset values:** `addr_sel` = 1 (master 0 parked), `data_sel` = 0. `hready_m` then evaluates to `~hreq | {…,hready_in}` combinationally.
- **Registered outputs:** `addr_sel` and `data_sel`. **Combinational outputs:** `hready_m` and `hsel_out`.
- **Re-arbitration latency:** 1 cycle after the owner's last accepted beat, i.e. its next `htrans` is NONSEQ or IDLE with `hready_in` = 1.
- **Wait states:** any `hready_in` = 0 cycle freezes both registers, even if requests change.
- **Reset mid-transfer:** reset wins unconditionally. Next cycle `addr_sel` = 1 and `data_sel` = 0, with no partial beat retained.
- **Simultaneous events:** if the owner drops its lock in the same cycle another master requests with `hready_in` = 1, the new owner is loaded that edge.

## Structure
- The shared `AHB_package` holds:
  - `htrans_t` enum with IDLE=0, BUSY=1, NONSEQ=2, SEQ=3;
  - `MAX_MASTER_NUM` = 16.
- One sub-module, `ahb_rr_picker`: purely combinational, (req, last_onehot) -> winner_onehot plus `any_req`. It is reusable by other ports.

## Test plan
- **Reset and parking:** assert `HRESET` for 2 cycles, no requests -> `addr_sel` = 4'b0001, `data_sel` = 0, `hready_m` = 4'b1111, `hsel_out` = 0.
- **Round-robin order:** `hreq` = 4'b1111 with single NONSEQ beats, `hready_in` = 1 -> grants go 1, 2, 3, 0, 1 on successive cycles. `data_sel` lags `addr_sel` by 1 cycle.
- **Burst hold:** master 2 owns an INCR4 (NONSEQ, SEQ×3) while master 0 requests -> owner stays 2 for 4 beats. Master 0 is granted on the edge after the last SEQ is accepted, and `hready_m[0]` = 0 throughout.
- **Wait states:** slave inserts `hready_in` = 0 for 3 cycles during master 1's data phase -> `addr_sel` and `data_sel` frozen, and `hready_m[1]` = 0 for exactly 3 cycles.
- **Locked sequence:** master 3 holds `hmastlock` = 1 across 3 NONSEQ transfers with master 1 requesting -> no grant change until `hmastlock` drops, then master 1 is granted the next accepted cycle.
- **Reset mid-burst:** assert `HRESET` during master 2's SEQ beat -> next cycle `addr_sel` = 4'b0001 and `data_sel` = 0.
